// File: rtl/tmr_irq_pkg.sv
// -----------------------------------------------------------------------------
// tmr_irq_pkg
// Shared definitions for the 8-bit timer-pair interrupt controller:
//   - NUM_SRC / VEC_WIDTH sizing constants
//   - named source indices. The index order is also the priority order,
//     with the lowest index served first.
//   - the controller state enum
//   - a helper that turns a vector code into a one-hot source mask
// -----------------------------------------------------------------------------
package tmr_irq_pkg;

  localparam int NUM_SRC   = 6;
  localparam int VEC_WIDTH = 3;

  // Source indices; a lower index means a higher priority.
  localparam logic [VEC_WIDTH-1:0] SRC_CMIA0 = 3'd0;
  localparam logic [VEC_WIDTH-1:0] SRC_CMIB0 = 3'd1;
  localparam logic [VEC_WIDTH-1:0] SRC_OVI0  = 3'd2;
  localparam logic [VEC_WIDTH-1:0] SRC_CMIA1 = 3'd3;
  localparam logic [VEC_WIDTH-1:0] SRC_CMIB1 = 3'd4;
  localparam logic [VEC_WIDTH-1:0] SRC_OVI1  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  // One-hot mask selecting the source addressed by a vector code.
  function automatic logic [NUM_SRC-1:0] vec_onehot(input logic [VEC_WIDTH-1:0] v);
    return NUM_SRC'(1) << v;
  endfunction

endpackage

// File: rtl/tmr_irq_prio_enc.sv
// -----------------------------------------------------------------------------
// tmr_irq_prio_enc
// Combinational fixed-priority encoder. Bit 0 has the highest priority.
// Ports:
//   mask  : NUM_SRC candidate requests (already qualified by enables)
//   valid : at least one mask bit is set
//   idx   : index of the lowest set bit (0 when valid=0)
// -----------------------------------------------------------------------------
module tmr_irq_prio_enc
  import tmr_irq_pkg::*;
(
  input  logic [NUM_SRC-1:0]   mask,
  output logic                 valid,
  output logic [VEC_WIDTH-1:0] idx
);

  // above[i] is set when some higher-priority (lower index) bit is set.
  logic [NUM_SRC-1:0] above;
  logic [NUM_SRC-1:0] winner;

  assign above[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NUM_SRC; gi++) begin : g_above
      assign above[gi] = above[gi-1] | mask[gi-1];
    end
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_winner
      assign winner[gi] = mask[gi] & ~above[gi];
    end
  endgenerate

  // winner is one-hot or zero, so OR-ing the indices of its set bits
  // yields the encoded index.
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (winner[i]) begin
        idx = idx | VEC_WIDTH'(i);
      end
    end
  end

  assign valid = |mask;

endmodule

// File: rtl/tmr_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tmr_irq_ctrl
// Interrupt-request handler for the 8-bit timer pair. The six timer interrupt
// levels are edge-captured into a pending register and arbitrated by fixed
// priority. One request at a time is offered to the CPU over a req/ack
// handshake. An accepted ack produces a one-cycle one-hot flag_clr strobe
// back toward the TCSR of the serviced source.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   CMIA0..OVI1       : interrupt levels from the timer control logic
//   irq_en            : per-source enable, used only for arbitration
//   irq_req, irq_vec  : request and source index presented to the CPU
//   irq_ack           : CPU acknowledge, honoured only while irq_req=1
//   flag_clr          : one-cycle one-hot strobe clearing the serviced flag
//   pending           : latched pending sources, for status read
// -----------------------------------------------------------------------------
module tmr_irq_ctrl
  import tmr_irq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 CMIA0,
  input  logic                 CMIB0,
  input  logic                 OVI0,
  input  logic                 CMIA1,
  input  logic                 CMIB1,
  input  logic                 OVI1,
  input  logic [NUM_SRC-1:0]   irq_en,
  output logic                 irq_req,
  output logic [VEC_WIDTH-1:0] irq_vec,
  input  logic                 irq_ack,
  output logic [NUM_SRC-1:0]   flag_clr,
  output logic [NUM_SRC-1:0]   pending
);

  logic [NUM_SRC-1:0]   src;
  logic [NUM_SRC-1:0]   src_q_reg;
  logic [NUM_SRC-1:0]   rise;
  logic [NUM_SRC-1:0]   clr_mask;
  logic [NUM_SRC-1:0]   pending_reg,  pending_next;
  logic [NUM_SRC-1:0]   flag_clr_reg, flag_clr_next;
  logic [VEC_WIDTH-1:0] irq_vec_reg,  irq_vec_next;
  logic                 irq_req_reg,  irq_req_next;
  state_t               state_reg,    state_next;
  logic                 accept;
  logic                 enc_valid;
  logic [VEC_WIDTH-1:0] enc_idx;

  // Pack the individual lines in source-index order.
  assign src = {OVI1, CMIB1, CMIA1, OVI0, CMIB0, CMIA0};

  // src_q_reg resets to 0, so a line already high when reset is released
  // still shows up as a rising edge on the first active cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q_reg <= '0;
    end else begin
      src_q_reg <= src;
    end
  end

  assign rise = src & ~src_q_reg;

  // An ack counts only in REQ; anywhere else it is ignored.
  assign accept   = (state_reg == ST_REQ) && irq_ack;
  assign clr_mask = accept ? vec_onehot(irq_vec_reg) : '0;

  // Pending bits latch regardless of irq_en. A new edge in the same cycle
  // as the clear wins, so the bit stays pending.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pending
      assign pending_next[gi] = rise[gi] | (pending_reg[gi] & ~clr_mask[gi]);
    end
  endgenerate

  tmr_irq_prio_enc u_prio_enc (
    .mask  (pending_reg & irq_en),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  always_comb begin
    state_next   = state_reg;
    irq_vec_next = irq_vec_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (enc_valid) begin
          irq_vec_next = enc_idx;
          state_next   = ST_REQ;
        end
      end
      // The vector is frozen here. Later arrivals and enable changes do not
      // preempt the request.
      ST_REQ: begin
        if (irq_ack) begin
          state_next = ST_CLEAR;
        end
      end
      // Gives the TCSR one cycle to drop its level before arbitrating again.
      ST_CLEAR: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    irq_req_next  = (state_next == ST_REQ);
    flag_clr_next = clr_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      pending_reg  <= '0;
      flag_clr_reg <= '0;
      irq_vec_reg  <= '0;
      irq_req_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pending_reg  <= pending_next;
      flag_clr_reg <= flag_clr_next;
      irq_vec_reg  <= irq_vec_next;
      irq_req_reg  <= irq_req_next;
    end
  end

  assign irq_req  = irq_req_reg;
  assign irq_vec  = irq_vec_reg;
  assign flag_clr = flag_clr_reg;
  assign pending  = pending_reg;

endmodule

// File: tb/tb_tmr_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tmr_irq_ctrl
// Directed bench for tmr_irq_ctrl. Expected outputs are queued when the
// stimulus for a cycle is applied, then popped and compared against the
// DUT once that clock edge has taken effect.
// -----------------------------------------------------------------------------
module tb_tmr_irq_ctrl;
  import tmr_irq_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 CMIA0, CMIB0, OVI0, CMIA1, CMIB1, OVI1;
  logic [NUM_SRC-1:0]   irq_en;
  logic                 irq_req;
  logic [VEC_WIDTH-1:0] irq_vec;
  logic                 irq_ack;
  logic [NUM_SRC-1:0]   flag_clr;
  logic [NUM_SRC-1:0]   pending;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          kind;   // 0 irq_req, 1 irq_vec, 2 flag_clr, 3 pending
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  tmr_irq_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .CMIA0    (CMIA0),
    .CMIB0    (CMIB0),
    .OVI0     (OVI0),
    .CMIA1    (CMIA1),
    .CMIB1    (CMIB1),
    .OVI1     (OVI1),
    .irq_en   (irq_en),
    .irq_req  (irq_req),
    .irq_vec  (irq_vec),
    .irq_ack  (irq_ack),
    .flag_clr (flag_clr),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input string tag, input int kind, input logic [31:0] e);
    exp_t x;
    x.tag  = tag;
    x.kind = kind;
    x.exp  = e;
    sb.push_back(x);
  endtask

  // Queue a full expected output picture for the next edge.
  task automatic expect_out(input string tag, input logic req, input logic [2:0] vec,
                            input logic [5:0] fclr, input logic [5:0] pend);
    push({tag, ".req"},  0, 32'(req));
    push({tag, ".flag"}, 2, 32'(fclr));
    push({tag, ".pend"}, 3, 32'(pend));
    if (req) push({tag, ".vec"}, 1, 32'(vec));
  endtask

  // Advance one edge, then compare everything that was queued for it.
  task automatic step();
    exp_t        x;
    logic [31:0] obs;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      unique case (x.kind)
        0:       obs = 32'(irq_req);
        1:       obs = 32'(irq_vec);
        2:       obs = 32'(flag_clr);
        default: obs = 32'(pending);
      endcase
      checks++;
      assert (obs === x.exp)
        $display("chk %s observed=%0h expected=%0h ok", x.tag, obs, x.exp);
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", x.tag, obs, x.exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; irq_ack = 1'b0; irq_en = 6'b111111;
    CMIA0 = 0; CMIB0 = 0; OVI0 = 0; CMIA1 = 0; CMIB1 = 0; OVI1 = 1'b1;

    // Reset release with OVI1 already high.
    step();
    expect_out("reset", 0, 0, 6'b000000, 6'b000000);
    step();
    push("reset.vec", 1, 32'd0);
    rst = 1'b0;
    expect_out("ovi1_capture", 0, 0, 6'b000000, 6'b100000);
    step();
    expect_out("ovi1_req", 1, 5, 6'b000000, 6'b100000);
    step();
    irq_ack = 1'b1;
    expect_out("ovi1_ack", 0, 0, 6'b100000, 6'b000000);
    step();
    irq_ack = 1'b0;
    expect_out("ovi1_clear", 0, 0, 6'b000000, 6'b000000);
    step();
    // Held level does not re-set; ack while idle does nothing.
    irq_ack = 1'b1;
    expect_out("held_level_idle_ack", 0, 0, 6'b000000, 6'b000000);
    step();
    irq_ack = 1'b0; OVI1 = 1'b0;
    expect_out("idle_quiet", 0, 0, 6'b000000, 6'b000000);
    step();

    // CMIB1 and CMIA0 together: CMIA0 first, CMIB1 two cycles after ack.
    CMIA0 = 1'b1; CMIB1 = 1'b1;
    expect_out("dual_capture", 0, 0, 6'b000000, 6'b010001);
    step();
    expect_out("dual_req0", 1, 0, 6'b000000, 6'b010001);
    step();
    irq_ack = 1'b1;
    expect_out("dual_ack0", 0, 0, 6'b000001, 6'b010000);
    step();
    // Ack still high in CLEAR must not service anything.
    expect_out("dual_clear", 0, 0, 6'b000000, 6'b010000);
    step();
    irq_ack = 1'b0;
    expect_out("dual_req4", 1, 4, 6'b000000, 6'b010000);
    step();
    irq_ack = 1'b1;
    expect_out("dual_ack4", 0, 0, 6'b010000, 6'b000000);
    step();
    irq_ack = 1'b0; CMIA0 = 1'b0; CMIB1 = 1'b0;
    expect_out("dual_done", 0, 0, 6'b000000, 6'b000000);
    step();

    // Masked OVI0 stays pending without a request.
    irq_en = 6'b111011; OVI0 = 1'b1;
    expect_out("mask_capture", 0, 0, 6'b000000, 6'b000100);
    step();
    expect_out("mask_hold", 0, 0, 6'b000000, 6'b000100);
    step();
    irq_en = 6'b111111;
    expect_out("mask_enable_req", 1, 2, 6'b000000, 6'b000100);
    step();
    irq_ack = 1'b1;
    expect_out("mask_ack", 0, 0, 6'b000100, 6'b000000);
    step();
    irq_ack = 1'b0; OVI0 = 1'b0;
    expect_out("mask_done", 0, 0, 6'b000000, 6'b000000);
    step();

    // No preemption: CMIA0 arrives while vec=3 is requested.
    CMIA1 = 1'b1;
    expect_out("nopre_capture", 0, 0, 6'b000000, 6'b001000);
    step();
    expect_out("nopre_req3", 1, 3, 6'b000000, 6'b001000);
    step();
    CMIA0 = 1'b1;
    irq_en = 6'b000001;
    expect_out("nopre_arrive", 1, 3, 6'b000000, 6'b001001);
    step();
    expect_out("nopre_hold", 1, 3, 6'b000000, 6'b001001);
    step();
    irq_ack = 1'b1;
    expect_out("nopre_ack3", 0, 0, 6'b001000, 6'b000001);
    step();
    irq_ack = 1'b0; irq_en = 6'b111111;
    expect_out("nopre_clear", 0, 0, 6'b000000, 6'b000001);
    step();
    expect_out("nopre_req0", 1, 0, 6'b000000, 6'b000001);
    step();
    irq_ack = 1'b1;
    expect_out("nopre_ack0", 0, 0, 6'b000001, 6'b000000);
    step();
    irq_ack = 1'b0; CMIA0 = 1'b0; CMIA1 = 1'b0;
    expect_out("nopre_done", 0, 0, 6'b000000, 6'b000000);
    step();

    // CMIA1 re-rises in the ack cycle: set wins over clear.
    CMIA1 = 1'b1;
    expect_out("setwin_capture", 0, 0, 6'b000000, 6'b001000);
    step();
    CMIA1 = 1'b0;
    expect_out("setwin_req3", 1, 3, 6'b000000, 6'b001000);
    step();
    CMIA1 = 1'b1; irq_ack = 1'b1;
    expect_out("setwin_ack", 0, 0, 6'b001000, 6'b001000);
    step();
    irq_ack = 1'b0;
    expect_out("setwin_clear", 0, 0, 6'b000000, 6'b001000);
    step();
    expect_out("setwin_rereq", 1, 3, 6'b000000, 6'b001000);
    step();
    irq_ack = 1'b1;
    expect_out("setwin_ack2", 0, 0, 6'b001000, 6'b000000);
    step();
    irq_ack = 1'b0; CMIA1 = 1'b0;
    expect_out("setwin_done", 0, 0, 6'b000000, 6'b000000);
    step();

    // Reset during a request aborts it with no strobe.
    CMIB0 = 1'b1;
    expect_out("rstmid_capture", 0, 0, 6'b000000, 6'b000010);
    step();
    expect_out("rstmid_req1", 1, 1, 6'b000000, 6'b000010);
    step();
    rst = 1'b1; irq_ack = 1'b1; CMIB0 = 1'b0;
    expect_out("rstmid_abort", 0, 0, 6'b000000, 6'b000000);
    push("rstmid_abort.vec", 1, 32'd0);
    step();
    rst = 1'b0; irq_ack = 1'b0;
    expect_out("rstmid_after", 0, 0, 6'b000000, 6'b000000);
    step();
    expect_out("rstmid_idle", 0, 0, 6'b000000, 6'b000000);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
